// File: rtl/frame_reader_pkg.sv
// frame_reader shared types and constants.
// Burst address layout helper for DDR2 read commands.
package frame_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } state_e;

  localparam logic [2:0] CMD_READ = 3'b001;

  localparam int BASE_W = 6;
  localparam int ROW_W  = 10;
  localparam int COL_W  = 7;
  localparam int CX_W   = 10;
  localparam int CY_W   = 10;
  localparam int LANE_W = 2;
  localparam int ADDR_W = 31;

  function automatic logic [ADDR_W-1:0] burst_addr(
    input logic [BASE_W-1:0] base,
    input logic [CY_W-1:0]   cy,
    input logic [CX_W-1:0]   cx
  );
    return {6'b0, base, cy, cx[9:3], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
// A push while full is accepted when a pop happens the same cycle.
module sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/frame_reader.sv
// DDR2 frame-buffer read engine: raster-order burst reads,
// credit-limited return buffering, 24-bit pixel stream out.
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int H_PIXELS  = 800,
  parameter int V_LINES   = 600,
  parameter int BUF_WORDS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [31:0]   frame_base,
  output logic          ready,
  output logic          done,
  input  logic          af_full,
  output logic          af_wr_en,
  output logic [30:0]   af_addr_din,
  output logic [2:0]    af_cmd_din,
  input  logic          rdf_valid,
  input  logic [127:0]  rdf_dout,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [23:0]   pix_data,
  output logic          pix_sof,
  output logic          pix_eol,
  output logic          err
);

  localparam int CNT_W = $clog2(BUF_WORDS) + 1;
  localparam int SUM_W = CNT_W + 2;

  localparam logic [CX_W-1:0] CX_LAST = CX_W'(H_PIXELS - 8);
  localparam logic [CX_W-1:0] OX_LAST = CX_W'(H_PIXELS - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(V_LINES - 1);

  state_e state_q, state_d;

  logic [BASE_W-1:0] base_q, base_d;
  logic [CX_W-1:0]   cx_q, cx_d;
  logic [CY_W-1:0]   cy_q, cy_d;
  logic [CX_W-1:0]   ox_q, ox_d;
  logic [CY_W-1:0]   oy_q, oy_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              err_q, err_d;

  logic              start_acc;
  logic              issue_last;
  logic              pix_fire;
  logic              pix_last;
  logic              credit_ok;
  logic [SUM_W-1:0]  credit_sum;

  logic              fifo_push;
  logic              fifo_pop;
  logic [127:0]      fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  sync_fifo #(
    .WIDTH (128),
    .DEPTH (BUF_WORDS)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (rdf_dout),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Credits cover words in flight plus words already buffered.
  assign credit_sum = SUM_W'(outst_q)
                    + SUM_W'(fifo_count)
                    + SUM_W'(2);
  assign credit_ok  = credit_sum <= SUM_W'(BUF_WORDS);

  assign start_acc  = (state_q == ST_IDLE) && start;
  assign issue_last = (cx_q == CX_LAST) && (cy_q == CY_LAST);

  assign pix_valid  = !fifo_empty;
  assign pix_fire   = pix_valid && pix_ready;
  assign pix_last   = (ox_q == OX_LAST) && (oy_q == CY_LAST);
  assign fifo_pop   = pix_fire && (lane_q == 2'd3);
  assign fifo_push  = rdf_valid && (outst_q != '0);

  assign af_addr_din = burst_addr(base_q, cy_q, cx_q);
  assign af_cmd_din  = CMD_READ;
  assign pix_sof     = pix_valid && (ox_q == '0) && (oy_q == '0);
  assign pix_eol     = pix_valid && (ox_q == OX_LAST);
  assign err         = err_q;

  always_comb begin
    pix_data = fifo_rdata[23:0];
    unique case (lane_q)
      2'd0: pix_data = fifo_rdata[23:0];
      2'd1: pix_data = fifo_rdata[55:32];
      2'd2: pix_data = fifo_rdata[87:64];
      2'd3: pix_data = fifo_rdata[119:96];
      default: pix_data = fifo_rdata[23:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (af_wr_en && issue_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready    = (state_q == ST_IDLE);
    af_wr_en = (state_q == ST_ISSUE) && !af_full && credit_ok;
    done     = (state_q == ST_DRAIN) && pix_fire && pix_last;
  end

  always_comb begin
    base_d  = base_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    lane_d  = lane_q;
    outst_d = outst_q;
    err_d   = err_q | (rdf_valid && (outst_q == '0));

    if (start_acc) begin
      base_d = frame_base[27:22];
      cx_d   = '0;
      cy_d   = '0;
      ox_d   = '0;
      oy_d   = '0;
    end

    if (af_wr_en) begin
      if (cx_q == CX_LAST) begin
        cx_d = '0;
        cy_d = cy_q + CY_W'(1);
      end else begin
        cx_d = cx_q + CX_W'(8);
      end
    end

    if (pix_fire) begin
      lane_d = lane_q + LANE_W'(1);
      if (ox_q == OX_LAST) begin
        ox_d = '0;
        oy_d = (oy_q == CY_LAST) ? '0 : oy_q + CY_W'(1);
      end else begin
        ox_d = ox_q + CX_W'(1);
      end
    end

    if (af_wr_en) outst_d = outst_d + CNT_W'(2);
    if (fifo_push) outst_d = outst_d - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      base_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      lane_q  <= '0;
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      base_q  <= base_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      lane_q  <= lane_d;
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{frame_base[31:28], frame_base[21:0],
                         fifo_rdata[127:120], fifo_rdata[95:88],
                         fifo_rdata[63:56], fifo_rdata[31:24],
                         fifo_full};

endmodule

// File: doc/frame_reader.md
# frame_reader

DDR2 frame-buffer read engine, the read-side counterpart of the frame filler. On a start pulse it walks one frame in raster order, issuing DDR2 read commands (one per 8-pixel burst) into the address FIFO, collects the two 128-bit words each burst returns on the read-data FIFO, and unpacks them into a 24-bit pixel stream with valid/ready handshaking toward the display/video pipeline. Because the read-data FIFO cannot be back-pressured, a credit scheme guarantees the internal buffer never overflows.

## Interface
- H_PIXELS, 800, pixels per line; multiple of 8, ≤1024
- V_LINES, 600, lines per frame; ≤1024
- BUF_WORDS, 16, internal 128-bit word buffer depth; power of 2, ≥4
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clk edge)
- start  in  1  one-cycle request to read one frame; honoured only when ready==1
- frame_base  in  32  frame base; bits [27:22] captured on accepted start
- ready  out  1  engine idle, will accept start
- done  out  1  one-cycle pulse after last pixel of the frame is accepted
- af_full  in  1  DDR2 address FIFO full
- af_wr_en  out  1  push read command
- af_addr_din  out  31  burst address
- af_cmd_din  out  3  constant 3'b001 (read)
- rdf_valid  in  1  read-data word present (no back-pressure)
- rdf_dout  in  128  read-data word
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  consumer accepts pixel when pix_valid&&pix_ready
- pix_data  out  24  pixel RGB
- pix_sof  out  1  qualifies first pixel of frame (x=0,y=0)
- pix_eol  out  1  qualifies last pixel of each line
- err  out  1  sticky: rdf_valid received with zero outstanding words

## Operation
- States: IDLE, ISSUE, DRAIN. Reset → IDLE.
- IDLE: ready=1. start → capture frame_base[27:22], clear issue counters (cx=0, cy=0), → ISSUE. start in ISSUE/DRAIN ignored.
- ISSUE: af_wr_en = !af_full && credit_ok (combinational). On push: cx += 8; at cx==H_PIXELS-8, cx←0, cy+=1; push of (H_PIXELS-8, V_LINES-1) → DRAIN.
- af_addr_din = {6'b0, base[27:22], cy[9:0], cx[9:3], 2'b00}; stable while af_wr_en low.
- Credits: outstanding (words requested, not yet returned) += 2 per push, -=1 per rdf_valid; both same cycle net +1. credit_ok = outstanding + buf_count + 2 ≤ BUF_WORDS.
- rdf_valid with outstanding==0: word discarded, err←1 (cleared only by reset).
- Unpack: each word yields 4 pixels, lane 0 first: [23:0], [55:32], [87:64], [119:96]; upper bytes ignored. First word of burst = pixels x..x+3, second = x+4..x+7. Word popped when lane 3 accepted.
- Output counters (ox, oy) advance on each accepted pixel; pix_sof = pix_valid && ox==0 && oy==0; pix_eol = pix_valid && ox==H_PIXELS-1.
- DRAIN: → IDLE with done pulse on the cycle the last pixel (ox=H-1, oy=V-1) is accepted; ready=1 the following cycle.

## Timing
- Reset values: ready=1, done=0, af_wr_en=0, pix_valid=0, pix_sof=0, pix_eol=0, err=0; buffer flushed, all counters 0.
- start accepted at edge N → first af_wr_en possible in cycle N+1.
- rdf_valid word at edge N → pix_valid for its lane 0 in cycle N+1 (if buffer was empty and no prior pixels pending).
- Sustained throughput: 1 pixel/cycle while pix_ready=1 and data buffered.
- pix_data/pix_valid held stable until accepted.
- Reset mid-frame aborts immediately; DDR must be quiescent at reset, otherwise late returns set err.

## Structure
- Package frame_reader_pkg: state enum, CMD_READ=3'b001, address field widths.
- One sub-module: sync_fifo (128-bit × BUF_WORDS, count output, same-cycle push/pop on full).

## Test plan
- H=16,V=2, frame_base=32'h1040_0000, af_full=0, pix_ready=1: four commands at addresses 31'h0008_0000, 31'h0008_0004, 31'h0008_0200, 31'h0008_0204; af_cmd_din=3'b001.
- Return words {…,32'h3,32'h2,32'h1,32'h0} then {…7,6,5,4}: pix_data 0..7 in order; pix_sof on pixel 0; pix_eol on pixels 15 and 31; done pulse after pixel 31, ready=1 next cycle.
- BUF_WORDS=4, pix_ready=0, data returned immediately: exactly 2 commands issued, af_wr_en stays 0 until pixels drained.
- af_full high 5 cycles mid-frame: af_wr_en=0, af_addr_din unchanged; issue resumes next cycle after release, no skipped address.
- rdf_valid pulsed in IDLE: err=1 and stays 1; no pix_valid.
- rst=0 during ISSUE after 2 commands: next cycle ready=1, pix_valid=0, af_wr_en=0; new start restarts at address 31'h0008_0000.
